// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester multiplexed memory bus arbiter.
package mem_bus_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int NREQ   = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RWAIT,
        RCAP
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus the multiplexed address/data memory bus.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req0_valid;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          req0_rvalid;

    logic          req1_valid;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          req1_rvalid;

    logic [DW-1:0] rdata;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic [DW-1:0] bus_in;
    logic          mem_ale;
    logic          mem_we;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  bus_in,
        output req0_ready, req0_rvalid,
        output req1_ready, req1_rvalid,
        output rdata, bus_out, bus_oe, mem_ale, mem_we
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output bus_in,
        input  req0_ready, req0_rvalid,
        input  req1_ready, req1_rvalid,
        input  rdata, bus_out, bus_oe, mem_ale, mem_we
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin tie-break; last_grant also names the owner of the
// transfer in progress, since it only moves on acceptance.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_grant,
    output logic            o_last_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = '0;
        if (i_accept) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_grant <= 1'b1;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end
    end

    assign o_last_grant = r_last_grant;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two requesters onto a multiplexed address/data memory bus
// with a fixed ADDR/WDATA or ADDR/RWAIT/RCAP sequence.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    mem_bus_arbiter_if.master bus
);

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_rvalid;

    logic [NREQ-1:0] w_valid;
    logic [NREQ-1:0] w_grant;
    logic            w_idle;
    logic            w_accept;
    logic            w_last_grant;
    logic [DW-1:0]   w_bus_out;
    logic            w_bus_oe;
    logic            w_ale;
    logic            w_we;

    assign w_valid = {bus.req1_valid, bus.req0_valid};
    // Ready must stay low while reset is held, even though state reads IDLE.
    assign w_idle  = (r_state == IDLE) && RST;

    rr_arb2 u_arb (
        .CLK          (CLK),
        .RST          (RST),
        .i_valid      (w_valid),
        .i_accept     (w_idle),
        .o_grant      (w_grant),
        .o_last_grant (w_last_grant)
    );

    assign w_accept = |w_grant;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= '0;
            if (w_accept) begin
                unique case (1'b1)
                    w_grant[0]: begin
                        r_we    <= bus.req0_we;
                        r_addr  <= bus.req0_addr;
                        r_wdata <= bus.req0_wdata;
                    end
                    w_grant[1]: begin
                        r_we    <= bus.req1_we;
                        r_addr  <= bus.req1_addr;
                        r_wdata <= bus.req1_wdata;
                    end
                    default: ;
                endcase
            end
            if (r_state == RCAP) begin
                r_rdata  <= bus.bus_in;
                r_rvalid <= w_last_grant ? 2'b10 : 2'b01;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_bus_out = '0;
        w_bus_oe  = 1'b0;
        w_ale     = 1'b0;
        w_we      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = ADDR;
            end
            ADDR: begin
                w_bus_out = DW'(r_addr);
                w_bus_oe  = 1'b1;
                w_ale     = 1'b1;
                w_next    = r_we ? WDATA : RWAIT;
            end
            WDATA: begin
                w_bus_out = r_wdata;
                w_bus_oe  = 1'b1;
                w_we      = 1'b1;
                w_next    = IDLE;
            end
            RWAIT:   w_next = RCAP;
            RCAP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.req0_ready  = w_grant[0];
    assign bus.req1_ready  = w_grant[1];
    assign bus.req0_rvalid = r_rvalid[0];
    assign bus.req1_rvalid = r_rvalid[1];
    assign bus.rdata       = r_rdata;
    assign bus.bus_out     = w_bus_out;
    assign bus.bus_oe      = w_bus_oe;
    assign bus.mem_ale     = w_ale;
    assign bus.mem_we      = w_we;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random checks of mem_bus_arbiter against a bus-level memory.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    mem_bus_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_bus_arbiter #(.AW(8), .DW(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Memory on the shared bus: content defaults to addr+0x10.
    logic [7:0] mem [256];
    logic [7:0] m_alat;
    bit         m_ok;

    always @(posedge CLK) begin
        if (!m_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 16);
            m_alat <= 8'h00;
            m_ok   <= 1'b1;
        end else begin
            if (bus.mem_ale) m_alat <= bus.bus_out;
            if (bus.mem_we) mem[m_alat] <= bus.bus_out;
        end
    end

    assign bus.bus_in = bus.bus_oe ? bus.bus_out : mem[m_alat];

    int n_chk;
    int n_pass;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(int n, bit v, bit we, logic [7:0] a, logic [7:0] d);
        if (n == 0) begin
            bus.req0_valid = v;
            bus.req0_we    = we;
            bus.req0_addr  = a;
            bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v;
            bus.req1_we    = we;
            bus.req1_addr  = a;
            bus.req1_wdata = d;
        end
    endtask

    function automatic logic [31:0] rdy();
        return 32'({bus.req1_ready, bus.req0_ready});
    endfunction

    function automatic logic [31:0] rv();
        return 32'({bus.req1_rvalid, bus.req0_rvalid});
    endfunction

    function automatic logic [31:0] ctl();
        return 32'({bus.bus_oe, bus.mem_ale, bus.mem_we});
    endfunction

    // Reference model for random traffic
    logic [7:0] ref_mem [256];
    bit         m_busy;
    bit         m_we;
    bit         m_own;
    bit         m_last;
    int         m_cnt;
    logic [7:0] m_exp;
    int         n_acc;
    int         n_rd;
    int         n_rv;

    task automatic mon_step();
        logic [1:0] v;
        logic [1:0] er;
        logic [1:0] ev;
        logic       eo;
        logic [7:0] a;
        logic [7:0] d;
        v = {bus.req1_valid, bus.req0_valid};
        if (m_busy) m_cnt++;
        eo = m_busy && (m_cnt == 1 || (m_we && m_cnt == 2));
        chk("rnd_oe", 32'(bus.bus_oe), 32'(eo));
        ev = (m_busy && !m_we && m_cnt == 4) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        chk("rnd_rv", rv(), 32'(ev));
        if (ev != 2'b00) chk("rnd_rdata", 32'(bus.rdata), 32'(m_exp));
        n_rv += int'(bus.req0_rvalid) + int'(bus.req1_rvalid);
        if (m_busy && m_cnt == (m_we ? 3 : 4)) m_busy = 1'b0;
        chk("rnd_one", 32'($countones({bus.req1_ready, bus.req0_ready}) <= 1), 32'd1);
        er = m_busy ? 2'b00 : (v == 2'b11 ? (m_last ? 2'b01 : 2'b10) : v);
        chk("rnd_rdy", rdy(), 32'(er));
        if (er != 2'b00) begin
            m_own  = er[1];
            m_last = er[1];
            m_we   = m_own ? bus.req1_we : bus.req0_we;
            a      = m_own ? bus.req1_addr : bus.req0_addr;
            d      = m_own ? bus.req1_wdata : bus.req0_wdata;
            if (m_we) begin
                ref_mem[a] = d;
            end else begin
                n_rd++;
                m_exp = ref_mem[a];
            end
            m_busy = 1'b1;
            m_cnt  = 0;
            n_acc++;
        end
    endtask

    initial begin
        int cyc;
        drv(0, 1'b1, 1'b0, 8'h00, 8'h00);
        drv(1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Reset state with both requesters asking
        repeat (3) tick();
        chk("rst_rdy", rdy(), 32'd0);
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_out", 32'(bus.bus_out), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_rv", rv(), 32'd0);
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
        RST = 1'b1;
        tick();

        // Single read of 0x02
        drv(0, 1'b1, 1'b0, 8'h02, 8'h00);
        #1;
        chk("rd_rdy", rdy(), 32'b01);
        tick();
        drv(0, 1'b0, 1'b0, 8'h02, 8'h00);
        chk("rd_addr", 32'(bus.bus_out), 32'h02);
        chk("rd_actl", ctl(), 32'b110);
        tick();
        chk("rd_turn", ctl(), 32'b000);
        tick();
        chk("rd_cap", ctl(), 32'b000);
        tick();
        chk("rd_rv", rv(), 32'b01);
        chk("rd_data", 32'(bus.rdata), 32'h12);
        tick();
        chk("rd_rv_pulse", rv(), 32'b00);

        // Single write 0xFF <= 0xAA from req1, then read it back
        drv(1, 1'b1, 1'b1, 8'hFF, 8'hAA);
        #1;
        chk("wr_rdy", rdy(), 32'b10);
        tick();
        drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("wr_addr", 32'(bus.bus_out), 32'hFF);
        chk("wr_actl", ctl(), 32'b110);
        tick();
        chk("wr_data", 32'(bus.bus_out), 32'hAA);
        chk("wr_dctl", ctl(), 32'b101);
        tick();
        chk("wr_idle", ctl(), 32'b000);
        chk("wr_idle_out", 32'(bus.bus_out), 32'h00);
        chk("rd_hold", 32'(bus.rdata), 32'h12);
        drv(0, 1'b1, 1'b0, 8'hFF, 8'h00);
        #1;
        chk("rb_rdy", rdy(), 32'b01);
        tick();
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        chk("rb_rv", rv(), 32'b01);
        chk("rb_data", 32'(bus.rdata), 32'hAA);

        // Address churn after acceptance
        drv(0, 1'b1, 1'b0, 8'h01, 8'h00);
        #1;
        chk("ch_rdy", rdy(), 32'b01);
        tick();
        drv(0, 1'b0, 1'b0, 8'h03, 8'h00);
        repeat (3) tick();
        chk("ch_rv", rv(), 32'b01);
        chk("ch_data", 32'(bus.rdata), 32'h11);

        // Contention from reset: 0,1,0,1 every 4 cycles
        RST = 1'b0;
        tick();
        drv(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drv(1, 1'b1, 1'b0, 8'h20, 8'h00);
        RST = 1'b1;
        #1;
        for (int c = 0; c <= 12; c++) begin
            chk("ct_rdy", rdy(), (c % 8 == 0) ? 32'b01 : (c % 8 == 4) ? 32'b10 : 32'b00);
            if (c == 4) begin
                chk("ct_rv0", rv(), 32'b01);
                chk("ct_d0", 32'(bus.rdata), 32'h20);
            end
            if (c == 8) begin
                chk("ct_rv1", rv(), 32'b10);
                chk("ct_d1", 32'(bus.rdata), 32'h30);
            end
            tick();
        end
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (5) tick();

        // Reset during WDATA aborts the write to 0xFE
        drv(0, 1'b1, 1'b1, 8'hFE, 8'h99);
        #1;
        chk("ab_rdy", rdy(), 32'b01);
        tick();
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("ab_wdata", ctl(), 32'b101);
        drv(1, 1'b1, 1'b0, 8'h00, 8'h00);
        RST = 1'b0;
        #1;
        chk("ab_ctl", ctl(), 32'b000);
        chk("ab_out", 32'(bus.bus_out), 32'h00);
        chk("ab_rdata", 32'(bus.rdata), 32'h00);
        chk("ab_rdy0", rdy(), 32'b00);
        chk("ab_rv", rv(), 32'b00);
        repeat (2) tick();
        drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
        RST = 1'b1;
        tick();
        drv(0, 1'b1, 1'b0, 8'hFE, 8'h00);
        #1;
        tick();
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        chk("ab_rb_rv", rv(), 32'b01);
        chk("ab_rb_data", 32'(bus.rdata), 32'h0E);

        // Random mixed traffic
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 16);
        ref_mem[8'hFF] = 8'hAA;
        m_busy = 1'b0;
        m_last = 1'b1;
        n_acc  = 0;
        n_rd   = 0;
        n_rv   = 0;
        cyc    = 0;
        while (n_acc < 200 && cyc < 4000) begin
            drv(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
            drv(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
            @(negedge CLK);
            mon_step();
            tick();
            cyc++;
        end
        chk("rnd_count", 32'(n_acc >= 200), 32'd1);
        drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            mon_step();
            tick();
        end
        chk("rnd_rvcnt", 32'(n_rv), 32'(n_rd));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
